bitonic_topk_pipe: RTL and testbench
====================================

// Module: bitonic_topk_pipe
// PURPOSE
//  Parametrised, fully pipelined bitonic sorter for N = 2**LOG2_N inputs. Returns the top K sorted elements with their input indices.
//  Generalises the fixed 8/16-input sorters: any power-of-two length, run-time direction, index tracking, valid/ready backpressure.
//  Sits between the score producer and the top-k selection stage. Accepts one vector per cycle at full throughput.
// PARAMETERS
//  DATAWIDTH  8  bit width of each unsigned element
//  LOG2_N     4  log2 of input length; N = 2**LOG2_N, legal range 1..6
//  TOPK       4  outputs delivered, 1 <= TOPK <= N
// PORTS
//  clk_i     in   1                     clock, rising edge
//  rstn_i    in   1                     asynchronous reset, active low
//  valid_i   in   1                     input vector valid
//  ready_o   out  1                     block can accept input this cycle
//  desc_i    in   1                     1: descending (largest first); 0: ascending; sampled with data
//  x_i       in   [N-1:0][DATAWIDTH]    input vector; element i has index i
//  valid_o   out  1                     output vector valid
//  ready_i   in   1                     downstream accepts output
//  desc_o    out  1                     direction that produced the current output
//  y_o       out  [TOPK-1:0][DATAWIDTH] sorted values; y_o[0] is first in the selected order
//  idx_o     out  [TOPK-1:0][LOG2_N]    original input index of each y_o entry
// BEHAVIOUR
//  - Network: standard bitonic merge network of S = LOG2_N*(LOG2_N+1)/2 compare-exchange stages.
//    Every stage is registered. Data, index, direction bit and valid bit travel together.
//  - Comparison key: {value, index}. Within each compare-exchange stage the pair is ordered on this key.
//    For the final descending output, ties resolve to the lower index first. For ascending, ties also resolve to the lower index first.
//    Implementation: key = {value, desc ? ~index : index}. This gives a total order and deterministic output.
//  - Direction is carried per vector. Consecutive vectors with different desc_i sort independently, with no bubbles.
//  - Handshake: transfer in when valid_i & ready_o; transfer out when valid_o & ready_i.
//    adv = ready_i | ~valid_o. All stages shift on adv and hold otherwise (global stall). ready_o = adv (combinational from ready_i).
//  - Latency: S cycles from input transfer to valid_o when unstalled, e.g. LOG2_N=4 gives S=10. Throughput: 1 vector/cycle.
//  - valid_i with ~ready_o: the input is not captured, and the producer must hold it. Bubbles (valid_i=0 on adv) propagate as valid=0.
//  - Outputs hold stable while valid_o & ~ready_i. Output-side rules:
//    - y_o, idx_o and desc_o must not change until the transfer completes.
//    - valid_o must not drop until the transfer completes.
//  - Only the first TOPK lanes of the final stage drive y_o/idx_o. The remaining N-TOPK lanes are computed and discarded.
//  - Reset (async assert, sync deassert by the system) has these effects:
//    - all stage valid bits, data, index and dir registers go to 0;
//    - hence valid_o=0, y_o=0, idx_o=0, desc_o=0, and ready_o=1 after reset;
//    - reset mid-stream discards all in-flight vectors, with no partial output.
//  - Values are unsigned. No arithmetic beyond comparison, so no width growth. The index width is exactly LOG2_N.
//  - LOG2_N=1: S=1, a single compare-exchange.
// TESTING
//  1 LOG2_N=4, TOPK=4, desc=1, x=[3,9,1,15,7,0,12,5,2,14,6,11,8,4,13,10] (x[0] first) -> at cycle 10: y=[15,14,13,12], idx=[3,9,14,6].
//  2 Same x, desc=0 -> y=[0,1,2,3], idx=[5,2,8,0], desc_o=0.
//  3 All x=7, desc=1 -> y=[7,7,7,7], idx=[0,1,2,3]. Same all-7 vector with desc=0 -> idx=[0,1,2,3].
//  4 Back-to-back 20 random vectors with alternating desc and ready_i=1 -> 20 outputs on consecutive cycles starting at cycle 10, matching the reference model in order.
//  5 ready_i=0 for 5 cycles while the pipe is full -> ready_o=0, and outputs are held bit-stable. After release, no vector is lost or duplicated.
//  6 Assert rstn_i=0 with 3 vectors in flight -> valid_o=0 and all outputs 0 immediately. After release, only newly issued vectors appear.

Source files
------------

// File: rtl/bitonic_topk_pipe.sv
// Fully pipelined bitonic sorter over N = 2**LOG2_N unsigned elements with index tracking,
// per-vector direction and a global-stall valid/ready handshake; emits the first TOPK lanes.
module bitonic_topk_pipe #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LOG2_N    = 4,
  parameter int unsigned TOPK      = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic                                   desc_i,
  input  logic [(1<<LOG2_N)-1:0][DATAWIDTH-1:0]  x_i,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   desc_o,
  output logic [TOPK-1:0][DATAWIDTH-1:0]         y_o,
  output logic [TOPK-1:0][LOG2_N-1:0]            idx_o
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned S  = LOG2_N * (LOG2_N + 1) / 2;
  localparam int unsigned KW = DATAWIDTH + LOG2_N;

  typedef logic [N-1:0][DATAWIDTH-1:0] vec_t;
  typedef logic [N-1:0][LOG2_N-1:0]    ivec_t;

  vec_t        val_q  [S];
  vec_t        val_in [S];
  vec_t        val_d  [S];
  ivec_t       idx_q  [S];
  ivec_t       idx_in [S];
  ivec_t       idx_d  [S];
  logic [S-1:0] dir_q;
  logic [S-1:0] dir_in;
  logic [S-1:0] vld_q;
  logic [S-1:0] vld_in;

  logic [KW-1:0] key_a;
  logic [KW-1:0] key_b;
  logic          asc;
  logic          adv;

  // Global stall: every stage shifts together whenever the output slot is free or draining.
  assign adv     = ready_i | ~vld_q[S-1];
  assign ready_o = adv;
  assign valid_o = vld_q[S-1];
  assign desc_o  = dir_q[S-1];

  // Stage s consumes the registered result of stage s-1; stage 0 consumes the port.
  always_comb begin : stage_inputs
    val_in[0] = x_i;
    dir_in[0] = desc_i;
    vld_in[0] = valid_i;
    for (int i = 0; i < N; i++) begin
      idx_in[0][i] = LOG2_N'(i);
    end
    for (int s = 1; s < S; s++) begin
      val_in[s] = val_q[s-1];
      idx_in[s] = idx_q[s-1];
      dir_in[s] = dir_q[s-1];
      vld_in[s] = vld_q[s-1];
    end
  end

  // Compare-exchange network; stage (p,q) merges blocks of 2**p at distance 2**q.
  // Inverting the index in descending mode keeps lower indices first on equal values.
  always_comb begin : cmp_exch
    for (int s = 0; s < S; s++) begin
      val_d[s] = val_in[s];
      idx_d[s] = idx_in[s];
    end
    key_a = '0;
    key_b = '0;
    asc   = 1'b0;
    for (int p = 1; p <= int'(LOG2_N); p++) begin
      for (int q = p - 1; q >= 0; q--) begin
        for (int i = 0; i < int'(N); i++) begin
          int st;
          int l;
          st = p * (p - 1) / 2 + (p - 1 - q);
          l  = i ^ (1 << q);
          if (l > i) begin
            asc   = ((i & (1 << p)) == 0) ^ dir_in[st];
            key_a = {val_in[st][i], dir_in[st] ? ~idx_in[st][i] : idx_in[st][i]};
            key_b = {val_in[st][l], dir_in[st] ? ~idx_in[st][l] : idx_in[st][l]};
            if (asc ? (key_a > key_b) : (key_a < key_b)) begin
              val_d[st][i] = val_in[st][l];
              val_d[st][l] = val_in[st][i];
              idx_d[st][i] = idx_in[st][l];
              idx_d[st][l] = idx_in[st][i];
            end
          end
        end
      end
    end
  end

  // Pipeline registers; reset flushes every in-flight vector.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < S; s++) begin
        val_q[s] <= '0;
        idx_q[s] <= '0;
      end
      dir_q <= '0;
      vld_q <= '0;
    end else if (adv) begin
      for (int s = 0; s < S; s++) begin
        val_q[s] <= val_d[s];
        idx_q[s] <= idx_d[s];
      end
      dir_q <= dir_in;
      vld_q <= vld_in;
    end
  end

  always_comb begin : topk_lanes
    for (int t = 0; t < TOPK; t++) begin
      y_o[t]   = val_q[S-1][t];
      idx_o[t] = idx_q[S-1][t];
    end
  end

endmodule

// File: tb/tb_bitonic_topk_pipe.sv
// Directed bench for bitonic_topk_pipe (N=16, TOPK=4): hand-computed sorts, streaming,
// backpressure hold and mid-stream reset, checked with immediate assertions.
module tb_bitonic_topk_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned LG = 4;
  localparam int unsigned N  = 16;
  localparam int unsigned K  = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef logic [K-1:0][DW-1:0] yv_t;
  typedef logic [K-1:0][LG-1:0] iv_t;
  typedef struct {
    yv_t  y;
    iv_t  i;
    logic d;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic valid_i;
  logic ready_o;
  logic desc_i;
  vec_t x;
  logic valid_o;
  logic ready_i;
  logic desc_o;
  yv_t  y;
  iv_t  idx;

  int   total = 0;
  int   bad   = 0;
  int   cyc;
  int   n_out;
  int   first_out;
  int   last_out;
  exp_t sbq [$];

  bitonic_topk_pipe #(.DATAWIDTH(DW), .LOG2_N(LG), .TOPK(K)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .desc_i  (desc_i),
    .x_i     (x),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .desc_o  (desc_o),
    .y_o     (y),
    .idx_o   (idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Straightforward selection: repeatedly take the best unused element, lowest index on ties.
  function automatic void ref_topk(input vec_t xv, input logic d, output yv_t ey, output iv_t ei);
    logic [N-1:0] used;
    int best;
    used = '0;
    ey   = '0;
    ei   = '0;
    for (int r = 0; r < int'(K); r++) begin
      best = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (!used[i]) begin
          if (best < 0) best = i;
          else if (d ? (xv[i] > xv[best]) : (xv[i] < xv[best])) best = i;
        end
      end
      used[best] = 1'b1;
      ey[r] = xv[best];
      ei[r] = LG'(best);
    end
  endfunction

  function automatic vec_t rand_vec(input int unsigned maxv);
    vec_t v;
    for (int i = 0; i < int'(N); i++) v[i] = DW'($urandom_range(0, maxv));
    return v;
  endfunction

  // One clock: settle, score handshakes that will complete on the coming edge, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (valid_o && ready_i) begin
      if (sbq.size() == 0) begin
        chk("spurious_out", 64'(valid_o), 64'(1'b0));
      end else begin
        e = sbq.pop_front();
        chk("sb_y", 64'(y), 64'(e.y));
        chk("sb_idx", 64'(idx), 64'(e.i));
        chk("sb_desc", 64'(desc_o), 64'(e.d));
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (valid_i && ready_o) begin
      ref_topk(x, desc_i, e.y, e.i);
      e.d = desc_i;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_directed(input string tag, input vec_t xv, input logic d,
                              input yv_t ey, input iv_t ei);
    x       = xv;
    desc_i  = d;
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(ready_o), 64'(1'b1));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    x       = '0;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_early"}, 64'(valid_o), 64'(1'b0));
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 64'(valid_o), 64'(1'b1));
    chk({tag, "_y"}, 64'(y), 64'(ey));
    chk({tag, "_idx"}, 64'(idx), 64'(ei));
    chk({tag, "_desc"}, 64'(desc_o), 64'(d));
    @(posedge clk);
    #1;
    chk({tag, "_once"}, 64'(valid_o), 64'(1'b0));
  endtask

  initial begin
    vec_t xa;
    vec_t x7;
    yv_t  sy;
    iv_t  si;
    logic sd;

    rstn    = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    desc_i  = 1'b0;
    x       = '0;
    cyc     = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'(1'b0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_idx", 64'(idx), 64'(0));
    chk("rst_desc", 64'(desc_o), 64'(1'b0));
    chk("rst_ready", 64'(ready_o), 64'(1'b1));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed sorts of the reference vector and an all-equal vector.
    xa = {8'd10, 8'd13, 8'd4, 8'd8, 8'd11, 8'd6, 8'd14, 8'd2,
          8'd5, 8'd12, 8'd0, 8'd7, 8'd15, 8'd1, 8'd9, 8'd3};
    x7 = {N{8'd7}};
    run_directed("t1_desc", xa, 1'b1, 32'h0C0D0E0F, 16'h6E93);
    run_directed("t2_asc", xa, 1'b0, 32'h03020100, 16'h0825);
    run_directed("t3_tie_desc", x7, 1'b1, 32'h07070707, 16'h3210);
    run_directed("t3_tie_asc", x7, 1'b0, 32'h07070707, 16'h3210);

    // Back-to-back stream, alternating direction, narrow range on odd vectors for ties.
    sbq.delete();
    n_out     = 0;
    first_out = -1;
    last_out  = -1;
    cyc       = 0;
    ready_i   = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c < 20) begin
        x       = rand_vec((c % 2 == 1) ? 7 : 255);
        desc_i  = (c % 2 == 0);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      cycle();
    end
    chk("t4_count", 64'(n_out), 64'(20));
    chk("t4_first", 64'(first_out), 64'(10));
    chk("t4_last", 64'(last_out), 64'(29));
    chk("t4_drained", 64'(sbq.size()), 64'(0));

    // Fill the pipe, stall the output for five cycles, then drain.
    sbq.delete();
    n_out     = 0;
    first_out = -1;
    ready_i   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      x       = rand_vec(255);
      desc_i  = $urandom_range(0, 1) == 1;
      valid_i = 1'b1;
      cycle();
    end
    x       = rand_vec(31);
    desc_i  = 1'b1;
    ready_i = 1'b0;
    #1;
    sy = y;
    si = idx;
    sd = desc_o;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_ready_low", 64'(ready_o), 64'(1'b0));
      chk("t5_valid_held", 64'(valid_o), 64'(1'b1));
      chk("t5_y_held", 64'(y), 64'(sy));
      chk("t5_idx_held", 64'(idx), 64'(si));
      chk("t5_desc_held", 64'(desc_o), 64'(sd));
      cycle();
    end
    ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    repeat (14) cycle();
    chk("t5_count", 64'(n_out), 64'(13));
    chk("t5_drained", 64'(sbq.size()), 64'(0));

    // Reset with three vectors in flight, then only fresh vectors may emerge.
    sbq.delete();
    n_out = 0;
    for (int c = 0; c < 3; c++) begin
      x       = rand_vec(255);
      desc_i  = (c == 1);
      valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("t6_valid", 64'(valid_o), 64'(1'b0));
    chk("t6_y", 64'(y), 64'(0));
    chk("t6_idx", 64'(idx), 64'(0));
    chk("t6_desc", 64'(desc_o), 64'(1'b0));
    chk("t6_ready", 64'(ready_o), 64'(1'b1));
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      x       = rand_vec(255);
      desc_i  = (c == 0);
      valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0;
    repeat (14) cycle();
    chk("t6_count", 64'(n_out), 64'(2));
    chk("t6_drained", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
